// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
// Definitions shared by the serial receiver (sipo_rx) and the MSB-first PISO
// transmitter: the two-state framing FSM encoding and the bit-counter width.
// No ports; import with "import sipo_pkg::*;".
// ---------------------------------------------------------------------------
package sipo_pkg;

    // The framing FSM is either waiting for a sync bit or assembling a word.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit-counter width for a word of 'width' bits. It never drops below one
    // bit, so the counter stays a real vector at the smallest legal width.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// ---------------------------------------------------------------------------
// sipo_hold_reg
// Output holding register for sipo_rx. It holds a completed word behind a
// valid/ready handshake and flags words that arrive while it is still full.
//
// Ports
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   load_i     a completed word is offered this cycle
//   word_i     the completed word
//   ready_i    consumer accepts word_o while valid_o=1
//   clr_i      synchronous clear of overrun_o
//   word_o     held word, stable while valid_o=1
//   valid_o    held word is available
//   overrun_o  sticky: an offered word was dropped because the register was full
// ---------------------------------------------------------------------------
module sipo_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ready_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    // A word can be taken when the register is empty or is being emptied on
    // this same edge. Otherwise the new word is dropped and the old one kept.
    // The overrun set is applied after the clear so a coincident new overrun
    // wins over clr_i.
    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (clr_i) begin
            overrun_d = 1'b0;
        end
        if (load_i) begin
            if (!valid_q || ready_i) begin
                word_d  = word_i;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_o    = word_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_rx.sv
// ---------------------------------------------------------------------------
// sipo_rx
// Serial-in, parallel-out receiver. Serial bits qualified by ser_valid are
// assembled into WIDTH-bit words; sync marks bit 0 of a word. Completed words
// are handed to a holding register with a valid/ready handshake.
//
// Parameters
//   WIDTH       word length, 2..32
//   MSB_FIRST   1: first serial bit lands in dout[WIDTH-1]; 0: in dout[0]
//   CONTINUOUS  1: words follow back to back without a new sync
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   ser         serial data bit
//   ser_valid   qualifies ser this cycle
//   sync        ser is bit 0 of a new word (only with ser_valid=1)
//   dout        last completed word, stable while dout_valid=1
//   dout_valid  completed word available
//   dout_ready  consumer accepts dout
//   frame_err   one-cycle pulse: sync mid-word, partial word discarded
//   overrun     sticky: completed word dropped, holding register full
//   clr_err     synchronous clear of overrun
// ---------------------------------------------------------------------------
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int CONTINUOUS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser,
    input  logic             ser_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_err
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;
    logic             word_done;

    // MSB-first shifts left so the first bit ends up in the top position after
    // WIDTH shifts; LSB-first shifts right so it ends up in bit 0. A fresh word
    // starts from a cleared register holding only the sync bit.
    assign shifted    = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], ser}
                                         : {ser, shift_q[WIDTH-1:1]};
    assign first_word = (MSB_FIRST != 0) ? {{(WIDTH-1){1'b0}}, ser}
                                         : {ser, {(WIDTH-1){1'b0}}};

    // Framing FSM. In SHIFT a count of zero only occurs in continuous mode
    // right after a completed word; the next valid bit is bit 0 there, and a
    // sync on it is a normal word start rather than a framing error.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ser_valid && sync) begin
                    shift_d = first_word;
                    count_d = ONE;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_valid) begin
                    if (sync && (count_q != '0)) begin
                        frame_err_d = 1'b1;
                        shift_d     = first_word;
                        count_d     = ONE;
                    end else if (count_q == '0) begin
                        shift_d = first_word;
                        count_d = ONE;
                    end else if (count_q == LAST) begin
                        shift_d   = shifted;
                        count_d   = '0;
                        word_done = 1'b1;
                        state_d   = (CONTINUOUS != 0) ? SHIFT : IDLE;
                    end else begin
                        shift_d = shifted;
                        count_d = count_q + ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    // The completed word is the shift register including the bit accepted this
    // cycle, so it is offered on the same edge that accepts the last bit.
    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (word_done),
        .word_i    (shifted),
        .ready_i   (dout_ready),
        .clr_i     (clr_err),
        .word_o    (dout),
        .valid_o   (dout_valid),
        .overrun_o (overrun)
    );

    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_rx.sv
// ---------------------------------------------------------------------------
// tb_sipo_rx
// Bench for sipo_rx. Two receivers share the serial inputs: one framed
// (CONTINUOUS=0) and one continuous (CONTINUOUS=1), both 8-bit MSB-first.
// Directed scenarios plus randomized bit streams; expected words come from
// grouping transmitted bits into words, first bit weighted highest.
// ---------------------------------------------------------------------------
module tb_sipo_rx;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rstN;
    logic ser;
    logic serValid;
    logic sync;
    logic doutReady;
    logic clrErr;

    logic [W-1:0] doutN, doutC;
    logic doutValidN, doutValidC;
    logic frameErrN, frameErrC;
    logic overrunN, overrunC;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] gotN[$];
    logic [W-1:0] gotC[$];
    int validCyclesN = 0;
    int frameCountN  = 0;
    int frameCountC  = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1), .CONTINUOUS(0)) dutN (
        .clk        (clk),
        .rst_n      (rstN),
        .ser        (ser),
        .ser_valid  (serValid),
        .sync       (sync),
        .dout       (doutN),
        .dout_valid (doutValidN),
        .dout_ready (doutReady),
        .frame_err  (frameErrN),
        .overrun    (overrunN),
        .clr_err    (clrErr)
    );

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1), .CONTINUOUS(1)) dutC (
        .clk        (clk),
        .rst_n      (rstN),
        .ser        (ser),
        .ser_valid  (serValid),
        .sync       (sync),
        .dout       (doutC),
        .dout_valid (doutValidC),
        .dout_ready (doutReady),
        .frame_err  (frameErrC),
        .overrun    (overrunC),
        .clr_err    (clrErr)
    );

    // Mid-cycle monitor: records accepted words and counts pulses.
    always @(negedge clk) begin
        if (doutValidN && doutReady) gotN.push_back(doutN);
        if (doutValidC && doutReady) gotC.push_back(doutC);
        if (doutValidN) validCyclesN++;
        if (frameErrN) frameCountN++;
        if (frameErrC) frameCountC++;
    end

    // Reference model: the j-th bit on the wire lands at position W-1-j.
    function automatic logic [W-1:0] assembleWord(input logic [W-1:0] timeBits);
        logic [W-1:0] w;
        w = '0;
        for (int j = 0; j < W; j++) w[W-1-j] = timeBits[j];
        return w;
    endfunction

    task automatic sendBit(input logic b, input logic s);
        @(posedge clk); #1;
        ser = b; serValid = 1'b1; sync = s;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            serValid = 1'b0; sync = 1'b0; ser = 1'($urandom);
        end
    endtask

    // Sends a word MSB first, optionally stalling after bit index stallAfter.
    task automatic sendWord(input logic [W-1:0] word, input int stallAfter,
                            input int stallLen, input logic syncFirst);
        for (int i = 0; i < W; i++) begin
            sendBit(word[W-1-i], (i == 0) ? syncFirst : 1'b0);
            if (i == stallAfter) idleCycles(stallLen);
        end
    endtask

    task automatic applyReset;
        @(negedge clk);
        rstN = 1'b0; serValid = 1'b0; sync = 1'b0; clrErr = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (doutN !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout_n: got %h, expected 00", doutN); end
        checks++; if (doutValidN !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_n: got %b, expected 0", doutValidN); end
        checks++; if (frameErrN !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_n: got %b, expected 0", frameErrN); end
        checks++; if (overrunN !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun_n: got %b, expected 0", overrunN); end
        checks++; if (doutC !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout_c: got %h, expected 00", doutC); end
        checks++; if (doutValidC !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_c: got %b, expected 0", doutValidC); end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_basic;
        int vBase;
        int gBase;
        gBase = gotN.size();
        vBase = validCyclesN;
        sendWord(8'hAA, -1, 0, 1'b1);
        idleCycles(1);
        @(negedge clk);
        checks++; if (doutValidN !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency: valid %b, expected 1", doutValidN); end
        checks++; if (doutN !== 8'hAA) begin errors++; $display("[TB] FAIL basic_dout: got %h, expected aa", doutN); end
        @(negedge clk);
        checks++; if (doutValidN !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_drop: valid %b, expected 0", doutValidN); end
        idleCycles(3);
        checks++; if (validCyclesN - vBase !== 1) begin errors++; $display("[TB] FAIL basic_valid_cycles: got %0d, expected 1", validCyclesN - vBase); end
        checks++; if (gotN.size() - gBase !== 1) begin errors++; $display("[TB] FAIL basic_count: got %0d words, expected 1", gotN.size() - gBase); end
    endtask

    task automatic test_stall;
        int gBase;
        int fBase;
        gBase = gotN.size();
        fBase = frameCountN;
        sendWord(8'hAA, 3, 3, 1'b1);
        idleCycles(4);
        checks++; if (gotN.size() - gBase !== 1) begin errors++; $display("[TB] FAIL stall_count: got %0d words, expected 1", gotN.size() - gBase); end
        else begin
            checks++; if (gotN[gBase] !== 8'hAA) begin errors++; $display("[TB] FAIL stall_dout: got %h, expected aa", gotN[gBase]); end
        end
        checks++; if (frameCountN - fBase !== 0) begin errors++; $display("[TB] FAIL stall_frame: got %0d pulses, expected 0", frameCountN - fBase); end
    endtask

    task automatic test_frame_err;
        int gBase;
        int fBase;
        gBase = gotN.size();
        fBase = frameCountN;
        for (int i = 0; i < 5; i++) sendBit(1'($urandom), i == 0);
        sendWord(8'hC3, -1, 0, 1'b1);
        idleCycles(4);
        checks++; if (frameCountN - fBase !== 1) begin errors++; $display("[TB] FAIL frame_pulses: got %0d, expected 1", frameCountN - fBase); end
        checks++; if (gotN.size() - gBase !== 1) begin errors++; $display("[TB] FAIL frame_count: got %0d words, expected 1", gotN.size() - gBase); end
        else begin
            checks++; if (gotN[gBase] !== 8'hC3) begin errors++; $display("[TB] FAIL frame_dout: got %h, expected c3", gotN[gBase]); end
        end
    endtask

    task automatic test_overrun;
        @(posedge clk); #1;
        doutReady = 1'b0;
        sendWord(8'h5A, -1, 0, 1'b1);
        idleCycles(2);
        sendWord(8'hFF, -1, 0, 1'b1);
        idleCycles(3);
        @(negedge clk);
        checks++; if (doutN !== 8'h5A) begin errors++; $display("[TB] FAIL overrun_hold: got %h, expected 5a", doutN); end
        checks++; if (doutValidN !== 1'b1) begin errors++; $display("[TB] FAIL overrun_valid: got %b, expected 1", doutValidN); end
        checks++; if (overrunN !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b, expected 1", overrunN); end
        @(posedge clk); #1; clrErr = 1'b1;
        @(posedge clk); #1; clrErr = 1'b0;
        @(negedge clk);
        checks++; if (overrunN !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear: got %b, expected 0", overrunN); end
        checks++; if (doutN !== 8'h5A) begin errors++; $display("[TB] FAIL overrun_hold2: got %h, expected 5a", doutN); end
        @(posedge clk); #1; doutReady = 1'b1;
        idleCycles(2);
        checks++; if (doutValidN !== 1'b0) begin errors++; $display("[TB] FAIL overrun_drain: valid %b, expected 0", doutValidN); end
        // A new overrun in the same cycle as clr_err must still set the flag.
        @(posedge clk); #1; doutReady = 1'b0; clrErr = 1'b1;
        sendWord(8'h11, -1, 0, 1'b1);
        idleCycles(2);
        sendWord(8'h22, -1, 0, 1'b1);
        idleCycles(1);
        @(negedge clk);
        checks++; if (overrunN !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set_wins: got %b, expected 1", overrunN); end
        checks++; if (doutN !== 8'h11) begin errors++; $display("[TB] FAIL overrun_hold3: got %h, expected 11", doutN); end
        @(posedge clk); #1; clrErr = 1'b0; doutReady = 1'b1;
        idleCycles(3);
    endtask

    task automatic test_random;
        logic [W-1:0] expQ[$];
        logic [W-1:0] timeBits;
        int gBase;
        int fBase;
        int expFrames;
        int n;
        expFrames = 0;
        gBase = gotN.size();
        fBase = frameCountN;
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                n = int'($urandom_range(1, W - 1));
                for (int i = 0; i < n; i++) sendBit(1'($urandom), i == 0);
                expFrames++;
            end
            for (int i = 0; i < W; i++) begin
                timeBits[i] = 1'($urandom);
                sendBit(timeBits[i], i == 0);
                if ($urandom_range(0, 4) == 0) idleCycles(int'($urandom_range(1, 3)));
            end
            expQ.push_back(assembleWord(timeBits));
            if ($urandom_range(0, 2) == 0) begin
                n = int'($urandom_range(1, 3));
                for (int j = 0; j < n; j++) sendBit(1'($urandom), 1'b0);
            end
            idleCycles(int'($urandom_range(0, 2)));
        end
        idleCycles(4);
        checks++; if (gotN.size() - gBase !== expQ.size()) begin errors++; $display("[TB] FAIL random_count: got %0d words, expected %0d", gotN.size() - gBase, expQ.size()); end
        for (int k = 0; k < expQ.size(); k++) begin
            if (gBase + k < gotN.size()) begin
                checks++; if (gotN[gBase+k] !== expQ[k]) begin errors++; $display("[TB] FAIL random_word%0d: got %h, expected %h", k, gotN[gBase+k], expQ[k]); end
            end
        end
        checks++; if (frameCountN - fBase !== expFrames) begin errors++; $display("[TB] FAIL random_frames: got %0d, expected %0d", frameCountN - fBase, expFrames); end
    endtask

    task automatic test_continuous;
        logic [W-1:0] expQ[$];
        logic [W-1:0] timeBits;
        int gBase;
        int fBase;
        applyReset();
        gBase = gotC.size();
        fBase = frameCountC;
        sendWord(8'h12, -1, 0, 1'b1);
        sendWord(8'h34, -1, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < W; i++) begin
                timeBits[i] = 1'($urandom);
                sendBit(timeBits[i], (i == 0) ? 1'($urandom) : 1'b0);
                if ($urandom_range(0, 4) == 0) idleCycles(int'($urandom_range(1, 3)));
            end
            expQ.push_back(assembleWord(timeBits));
        end
        idleCycles(4);
        checks++; if (gotC.size() - gBase !== 2 + expQ.size()) begin errors++; $display("[TB] FAIL cont_count: got %0d words, expected %0d", gotC.size() - gBase, 2 + expQ.size()); end
        if (gotC.size() - gBase >= 2) begin
            checks++; if (gotC[gBase] !== 8'h12) begin errors++; $display("[TB] FAIL cont_word0: got %h, expected 12", gotC[gBase]); end
            checks++; if (gotC[gBase+1] !== 8'h34) begin errors++; $display("[TB] FAIL cont_word1: got %h, expected 34", gotC[gBase+1]); end
        end
        for (int k = 0; k < expQ.size(); k++) begin
            if (gBase + 2 + k < gotC.size()) begin
                checks++; if (gotC[gBase+2+k] !== expQ[k]) begin errors++; $display("[TB] FAIL cont_rand%0d: got %h, expected %h", k, gotC[gBase+2+k], expQ[k]); end
            end
        end
        checks++; if (frameCountC - fBase !== 0) begin errors++; $display("[TB] FAIL cont_frames: got %0d, expected 0", frameCountC - fBase); end
    endtask

    task automatic test_reset_mid;
        int gBaseN;
        int gBaseC;
        for (int i = 0; i < 4; i++) sendBit(1'($urandom), i == 0);
        @(posedge clk); #2;
        rstN = 1'b0;
        #1;
        checks++; if (doutN !== 8'h00) begin errors++; $display("[TB] FAIL rmid_dout_n: got %h, expected 00", doutN); end
        checks++; if (doutValidN !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid_n: got %b, expected 0", doutValidN); end
        checks++; if (frameErrN !== 1'b0) begin errors++; $display("[TB] FAIL rmid_frame_n: got %b, expected 0", frameErrN); end
        checks++; if (overrunN !== 1'b0) begin errors++; $display("[TB] FAIL rmid_overrun_n: got %b, expected 0", overrunN); end
        checks++; if (doutC !== 8'h00) begin errors++; $display("[TB] FAIL rmid_dout_c: got %h, expected 00", doutC); end
        serValid = 1'b0; sync = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        gBaseN = gotN.size();
        gBaseC = gotC.size();
        for (int i = 0; i < 4; i++) sendBit(1'($urandom), 1'b0);
        sendWord(8'h81, -1, 0, 1'b1);
        idleCycles(4);
        checks++; if (gotN.size() - gBaseN !== 1) begin errors++; $display("[TB] FAIL rmid_count_n: got %0d words, expected 1", gotN.size() - gBaseN); end
        else begin
            checks++; if (gotN[gBaseN] !== 8'h81) begin errors++; $display("[TB] FAIL rmid_word_n: got %h, expected 81", gotN[gBaseN]); end
        end
        checks++; if (gotC.size() - gBaseC !== 1) begin errors++; $display("[TB] FAIL rmid_count_c: got %0d words, expected 1", gotC.size() - gBaseC); end
        else begin
            checks++; if (gotC[gBaseC] !== 8'h81) begin errors++; $display("[TB] FAIL rmid_word_c: got %h, expected 81", gotC[gBaseC]); end
        end
    endtask

    initial begin
        rstN = 1'b0; ser = 1'b0; serValid = 1'b0; sync = 1'b0;
        doutReady = 1'b1; clrErr = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_frame_err();
        test_overrun();
        test_random();
        test_continuous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
